// File: rtl/cfg_pkg.sv
// Shared types and default sizing for the scan-chain config loader.
// The readback pass is enabled by defining CFG_READBACK_EN.
package cfg_pkg;

  localparam int unsigned DEF_CHAIN_LEN = 96;
  localparam int unsigned DEF_WORD_W    = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    VERIFY = 2'd2,
    FINISH = 2'd3
  } cfg_state_e;

endpackage

// File: rtl/cfg_serializer.sv
// Word-to-bit serializer: one holding register, a bit-in-word index, and
// ready logic that refills on the final bit so words stream without bubbles.
module cfg_serializer
  import cfg_pkg::*;
#(
  parameter int unsigned WORD_W = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              flush_i,
  input  logic [WORD_W-1:0] word_data_i,
  input  logic              word_valid_i,
  output logic              word_ready_o,
  output logic              bit_valid_o,
  output logic              bit_o
);

  localparam int unsigned IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  logic [WORD_W-1:0] hold_q, hold_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              full_q, full_d;
  logic              last_bit;
  logic              accept;

  assign last_bit     = full_q && (idx_q == IDX_W'(WORD_W - 1));
  assign word_ready_o = en_i && !flush_i && (!full_q || last_bit);
  assign accept       = word_ready_o && word_valid_i;
  assign bit_valid_o  = full_q;
  assign bit_o        = full_q & hold_q[0];

  // Flush wins over everything so a pass ends with the register empty.
  always_comb begin
    hold_d = hold_q;
    idx_d  = idx_q;
    full_d = full_q;
    if (flush_i || !en_i) begin
      hold_d = '0;
      idx_d  = '0;
      full_d = 1'b0;
    end else if (accept) begin
      hold_d = word_data_i;
      idx_d  = '0;
      full_d = 1'b1;
    end else if (full_q) begin
      hold_d = hold_q >> 1;
      idx_d  = idx_q + IDX_W'(1);
      if (last_bit) begin
        idx_d  = '0;
        full_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      idx_q  <= '0;
      full_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      idx_q  <= idx_d;
      full_q <= full_d;
    end
  end

endmodule

// File: rtl/cfg_chain_loader.sv
// Streams host config words bit-serially into a switch-box scan chain.
// Define CFG_READBACK_EN to add a second pass that checks so against si.
module cfg_chain_loader
  import cfg_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int unsigned WORD_W    = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              si,
  output logic              cfg_shift,
  input  logic              so,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);

  cfg_state_e       state_q;
  logic [CNT_W-1:0] shift_cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             ser_en;
  logic             bit_valid;
  logic             bit_val;
  logic             last_chain_bit;

  assign ser_en         = (state_q == LOAD) || (state_q == VERIFY);
  assign last_chain_bit = bit_valid && (shift_cnt_q == CNT_W'(CHAIN_LEN - 1));

  cfg_serializer #(
    .WORD_W (WORD_W)
  ) u_ser (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (ser_en),
    .flush_i      (last_chain_bit),
    .word_data_i  (word_data),
    .word_valid_i (word_valid),
    .word_ready_o (word_ready),
    .bit_valid_o  (bit_valid),
    .bit_o        (bit_val)
  );

  assign cfg_shift = bit_valid;
  assign si        = bit_val;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef CFG_READBACK_EN
  logic err_q;
  assign err = err_q;
`else
  logic unused_so;
  assign unused_so = so;
  assign err       = 1'b0;
`endif

  // The final chain bit flushes the serializer, so leftover word bits never reach si.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef CFG_READBACK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= LOAD;
            shift_cnt_q <= '0;
            busy_q      <= 1'b1;
`ifdef CFG_READBACK_EN
            err_q       <= 1'b0;
`endif
          end
        end
        LOAD: begin
          if (last_chain_bit) begin
            shift_cnt_q <= '0;
`ifdef CFG_READBACK_EN
            state_q     <= VERIFY;
`else
            state_q     <= FINISH;
            done_q      <= 1'b1;
`endif
          end else if (bit_valid) begin
            shift_cnt_q <= shift_cnt_q + CNT_W'(1);
          end
        end
`ifdef CFG_READBACK_EN
        VERIFY: begin
          if (bit_valid && (so != bit_val)) begin
            err_q <= 1'b1;
          end
          if (last_chain_bit) begin
            shift_cnt_q <= '0;
            state_q     <= FINISH;
            done_q      <= 1'b1;
          end else if (bit_valid) begin
            shift_cnt_q <= shift_cnt_q + CNT_W'(1);
          end
        end
`endif
        FINISH: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
